// File: rtl/ysyx_23060072_fetch_ctrl_pkg.sv
// Shared constants, state encoding and immediate decoders for the fetch controller.
package ysyx_23060072_fetch_ctrl_pkg;

  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;
  localparam logic [31:0] RESET_PC   = 32'h8000_0000;

  typedef enum logic {
    FC_BOOT = 1'b0,
    FC_RUN  = 1'b1
  } fc_state_e;

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ysyx_23060072_fetch_ctrl_static_bp.sv
// Static next-PC predictor: JAL and backward branches taken, everything else falls through.
module ysyx_23060072_static_bp
  import ysyx_23060072_fetch_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic        pred_taken,
  output logic [31:0] pred_next
);

  logic [6:0]  opcode;
  logic [31:0] jal_target;
  logic [31:0] br_target;
  logic [31:0] seq_next;

  assign opcode     = inst[6:0];
  assign jal_target = pc + imm_j(inst);
  assign br_target  = pc + imm_b(inst);
  assign seq_next   = pc + 32'd4;

  always_comb begin
    pred_taken = 1'b0;
    pred_next  = seq_next;
    if (opcode == OPC_JAL) begin
      pred_taken = 1'b1;
      pred_next  = jal_target;
    end else if (opcode == OPC_BRANCH && inst[31]) begin
      // inst[31] is imm_b[12]: a negative offset means a loop back-edge
      pred_taken = 1'b1;
      pred_next  = br_target;
    end
  end

endmodule

// File: rtl/ysyx_23060072_fetch_ctrl.sv
// PC register, boot FSM and IF/ID pipeline register feeding the decode stage.
//   state   | meaning
//   FC_BOOT | first edge after reset: hold pc, load a bubble
//   FC_RUN  | normal fetch: redirect > stall > advance
module ysyx_23060072_fetch_ctrl
  import ysyx_23060072_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P = RESET_PC,
  parameter int          XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic [XLEN-1:0] inst_rdata_i,
  output logic [XLEN-1:0] instr_addr_o,
  output logic [XLEN-1:0] instr_bpu_o,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_inst_o,
  output logic            if_id_pred_taken_o,
  output logic [XLEN-1:0] if_id_pred_pc_o
);

  fc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_taken_q, id_taken_d;
  logic [31:0] id_pred_q, id_pred_d;

  logic        pred_taken;
  logic [31:0] pred_next;

  ysyx_23060072_static_bp u_static_bp (
    .pc         (pc_q),
    .inst       (inst_rdata_i),
    .pred_taken (pred_taken),
    .pred_next  (pred_next)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_taken_d = id_taken_q;
    id_pred_d  = id_pred_q;
    if (redirect_valid_i || state_q == FC_BOOT) begin
      // Bubble: the fetch in flight is either wrong-path or pre-boot
      state_d    = FC_RUN;
      if (redirect_valid_i) pc_d = {redirect_pc_i[31:2], 2'b00};
      valid_d    = 1'b0;
      id_pc_d    = 32'h0;
      id_inst_d  = INST_NOP;
      id_taken_d = 1'b0;
      id_pred_d  = 32'h0;
    end else if (!stall_i) begin
      pc_d       = pred_next;
      valid_d    = 1'b1;
      id_pc_d    = pc_q;
      id_inst_d  = inst_rdata_i;
      id_taken_d = pred_taken;
      id_pred_d  = pred_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FC_BOOT;
      pc_q       <= RESET_PC_P;
      valid_q    <= 1'b0;
      id_pc_q    <= 32'h0;
      id_inst_q  <= INST_NOP;
      id_taken_q <= 1'b0;
      id_pred_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_taken_q <= id_taken_d;
      id_pred_q  <= id_pred_d;
    end
  end

  assign instr_addr_o       = pc_q;
  assign instr_bpu_o        = pred_next;
  assign if_id_valid_o      = valid_q;
  assign if_id_pc_o         = id_pc_q;
  assign if_id_inst_o       = id_inst_q;
  assign if_id_pred_taken_o = id_taken_q;
  assign if_id_pred_pc_o    = id_pred_q;

endmodule
